// File: rtl/detector_proximidade_pkg.sv
// -----------------------------------------------------------------------------
// detector_proximidade_pkg
// Shared definitions for the multi-channel proximity detector.
// Holds the per-channel FSM state encoding. The encoding is fixed and shared
// with the SGA control FSM:
//   LONGE = 0, CONFIRMA_PERTO = 1, PERTO = 2, CONFIRMA_LONGE = 3.
// -----------------------------------------------------------------------------
package detector_proximidade_pkg;

  typedef enum logic [1:0] {
    LONGE          = 2'd0,
    CONFIRMA_PERTO = 2'd1,
    PERTO          = 2'd2,
    CONFIRMA_LONGE = 2'd3
  } estado_t;

endpackage

// File: rtl/canal_proximidade.sv
// -----------------------------------------------------------------------------
// canal_proximidade
// One proximity channel: hysteresis comparator, N-sample confirmation FSM and
// last-sample register. State is updated only when valida_i is high.
// Ports:
//   clock      in  1        system clock, rising edge
//   reset      in  1        asynchronous, active-high
//   limiar_i   in  LARGURA  near threshold
//   medida_i   in  LARGURA  distance sample for this channel
//   valida_i   in  1        medida_i carries a new sample this cycle
//   proximo_o  out 1        filtered near flag (decoded from the state register)
//   ultima_o   out LARGURA  last accepted sample
// -----------------------------------------------------------------------------
module canal_proximidade
  import detector_proximidade_pkg::*;
#(
  parameter int LARGURA    = 12,
  parameter int N_CONFIRMA = 3,
  parameter int HISTERESE  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] limiar_i,
  input  logic [LARGURA-1:0] medida_i,
  input  logic               valida_i,
  output logic               proximo_o,
  output logic [LARGURA-1:0] ultima_o
);

  localparam int CW = $clog2(N_CONFIRMA + 1);
  localparam logic [CW-1:0]    ULTIMO   = CW'(N_CONFIRMA - 1);
  localparam logic [LARGURA:0] HIST_EXT = (LARGURA + 1)'(HISTERESE);

  estado_t             estado_q, estado_d;
  logic [CW-1:0]       cont_q, cont_d;
  logic [LARGURA-1:0]  ultima_q;
  logic                perto, longe;

  // The far threshold is formed one bit wider so a threshold near the top
  // code cannot wrap; in that case no sample ever qualifies as far.
  assign perto = medida_i < limiar_i;
  assign longe = {1'b0, medida_i} >= ({1'b0, limiar_i} + HIST_EXT);

  // Next-state logic: cont counts consecutive qualifying samples in the
  // CONFIRMA_* states; any non-qualifying sample drops back and clears it.
  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    if (valida_i) begin
      case (estado_q)
        LONGE: begin
          if (perto) begin
            if (N_CONFIRMA == 1) begin
              estado_d = PERTO;
              cont_d   = '0;
            end else begin
              estado_d = CONFIRMA_PERTO;
              cont_d   = CW'(1);
            end
          end
        end
        CONFIRMA_PERTO: begin
          if (perto && cont_q == ULTIMO) begin
            estado_d = PERTO;
            cont_d   = '0;
          end else if (perto) begin
            cont_d   = cont_q + CW'(1);
          end else begin
            estado_d = LONGE;
            cont_d   = '0;
          end
        end
        PERTO: begin
          if (longe) begin
            if (N_CONFIRMA == 1) begin
              estado_d = LONGE;
              cont_d   = '0;
            end else begin
              estado_d = CONFIRMA_LONGE;
              cont_d   = CW'(1);
            end
          end
        end
        CONFIRMA_LONGE: begin
          if (longe && cont_q == ULTIMO) begin
            estado_d = LONGE;
            cont_d   = '0;
          end else if (longe) begin
            cont_d   = cont_q + CW'(1);
          end else begin
            estado_d = PERTO;
            cont_d   = '0;
          end
        end
        default: begin
          estado_d = LONGE;
          cont_d   = '0;
        end
      endcase
    end
  end

  // State, counter and last-sample registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= LONGE;
      cont_q   <= '0;
      ultima_q <= '0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      if (valida_i) begin
        ultima_q <= medida_i;
      end
    end
  end

  assign proximo_o = (estado_q == PERTO) || (estado_q == CONFIRMA_LONGE);
  assign ultima_o  = ultima_q;

endmodule

// File: rtl/detector_proximidade_n.sv
// -----------------------------------------------------------------------------
// detector_proximidade_n
// Multi-channel ultrasonic proximity detector with hysteresis and N-sample
// confirmation. Reports per-channel near flags, the nearest near channel and a
// one-cycle change event.
// Ports:
//   clock               in  1                 system clock, rising edge
//   reset               in  1                 asynchronous, active-high
//   limiar              in  LARGURA           near threshold
//   medidas             in  N_CANAIS*LARGURA  channel i at [i*LARGURA +: LARGURA]
//   medida_valida       in  N_CANAIS          per-channel new-sample strobe
//   proximo             out N_CANAIS          filtered near flag per channel
//   algum_proximo       out 1                 some channel near (registered)
//   canal_mais_proximo  out CW_CANAL          nearest near channel (registered)
//   evento              out 1                 pulse when proximo changed
// -----------------------------------------------------------------------------
module detector_proximidade_n
  import detector_proximidade_pkg::*;
#(
  parameter int N_CANAIS   = 2,
  parameter int LARGURA    = 12,
  parameter int N_CONFIRMA = 3,
  parameter int HISTERESE  = 2,
  localparam int CW_CANAL  = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [LARGURA-1:0]          limiar,
  input  logic [N_CANAIS*LARGURA-1:0] medidas,
  input  logic [N_CANAIS-1:0]         medida_valida,
  output logic [N_CANAIS-1:0]         proximo,
  output logic                        algum_proximo,
  output logic [CW_CANAL-1:0]         canal_mais_proximo,
  output logic                        evento
);

  logic [LARGURA-1:0]  ultima [N_CANAIS];
  logic [N_CANAIS-1:0] prox_ant_q;
  logic                evento_q, algum_q, algum_d;
  logic [CW_CANAL-1:0] canal_q, canal_d;
  logic [LARGURA-1:0]  melhor_val;

  for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
    canal_proximidade #(
      .LARGURA   (LARGURA),
      .N_CONFIRMA(N_CONFIRMA),
      .HISTERESE (HISTERESE)
    ) u_canal (
      .clock    (clock),
      .reset    (reset),
      .limiar_i (limiar),
      .medida_i (medidas[i*LARGURA +: LARGURA]),
      .valida_i (medida_valida[i]),
      .proximo_o(proximo[i]),
      .ultima_o (ultima[i])
    );
  end

  // Argmin over near channels. Strict less-than keeps the lowest index on
  // ties; with no near channel the index stays 0.
  always_comb begin
    algum_d    = 1'b0;
    canal_d    = '0;
    melhor_val = '1;
    for (int i = 0; i < N_CANAIS; i++) begin
      if (proximo[i] && (!algum_d || ultima[i] < melhor_val)) begin
        algum_d    = 1'b1;
        canal_d    = CW_CANAL'(i);
        melhor_val = ultima[i];
      end
    end
  end

  // Registered summary outputs and the change detector; both lag proximo by
  // one cycle, and any set of simultaneous bit flips gives a single pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      algum_q    <= 1'b0;
      canal_q    <= '0;
      prox_ant_q <= '0;
      evento_q   <= 1'b0;
    end else begin
      algum_q    <= algum_d;
      canal_q    <= canal_d;
      prox_ant_q <= proximo;
      evento_q   <= (proximo != prox_ant_q);
    end
  end

  assign algum_proximo      = algum_q;
  assign canal_mais_proximo = canal_q;
  assign evento             = evento_q;

endmodule

// File: tb/tb_detector_proximidade_n.sv
// -----------------------------------------------------------------------------
// tb_detector_proximidade_n
// Directed bench for detector_proximidade_n with two channels, 12-bit samples,
// 3-sample confirmation, hysteresis 2 and threshold 10 unless stated.
// -----------------------------------------------------------------------------
module tb_detector_proximidade_n;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] limiar;
  logic [23:0] medidas;
  logic [1:0]  medida_valida;
  logic [1:0]  proximo;
  logic        algum_proximo;
  logic [0:0]  canal_mais_proximo;
  logic        evento;

  int nVectors     = 0;
  int nMiscompares = 0;

  detector_proximidade_n #(
    .N_CANAIS  (2),
    .LARGURA   (12),
    .N_CONFIRMA(3),
    .HISTERESE (2)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .limiar            (limiar),
    .medidas           (medidas),
    .medida_valida     (medida_valida),
    .proximo           (proximo),
    .algum_proximo     (algum_proximo),
    .canal_mais_proximo(canal_mais_proximo),
    .evento            (evento)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one strobe on the channels in mask, starting at a negedge; returns
  // at the negedge right after the accepting posedge.
  task automatic applyStimulus(input logic [1:0] mask, input int v0, input int v1);
    if (mask[0]) medidas[11:0]  = 12'(v0);
    if (mask[1]) medidas[23:12] = 12'(v1);
    medida_valida = mask;
    @(negedge clock);
    medida_valida = 2'b00;
  endtask

  task automatic idleCycle();
    @(negedge clock);
  endtask

  task automatic pulseReset();
    medida_valida = 2'b00;
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    limiar        = 12'd10;
    medidas       = '0;
    medida_valida = 2'b00;
    #2;
    checkOutput("reset_proximo", 32'(proximo), 32'd0);
    checkOutput("reset_algum", 32'(algum_proximo), 32'd0);
    checkOutput("reset_evento", 32'(evento), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // 1: three near samples on ch0
    applyStimulus(2'b01, 9, 0);
    checkOutput("t1_after1", 32'(proximo), 32'd0);
    applyStimulus(2'b01, 9, 0);
    checkOutput("t1_after2", 32'(proximo), 32'd0);
    applyStimulus(2'b01, 9, 0);
    checkOutput("t1_after3", 32'(proximo), 32'd1);
    checkOutput("t1_evento_not_yet", 32'(evento), 32'd0);
    idleCycle();
    checkOutput("t1_evento", 32'(evento), 32'd1);
    checkOutput("t1_canal", 32'(canal_mais_proximo), 32'd0);
    checkOutput("t1_algum", 32'(algum_proximo), 32'd1);
    idleCycle();
    checkOutput("t1_evento_end", 32'(evento), 32'd0);

    // 2: a far sample resets the confirmation count
    pulseReset();
    applyStimulus(2'b01, 9, 0);
    applyStimulus(2'b01, 9, 0);
    applyStimulus(2'b01, 15, 0);
    checkOutput("t2_after15", 32'(proximo), 32'd0);
    applyStimulus(2'b01, 9, 0);
    applyStimulus(2'b01, 9, 0);
    checkOutput("t2_after_9_9", 32'(proximo), 32'd0);
    applyStimulus(2'b01, 9, 0);
    checkOutput("t2_third9", 32'(proximo), 32'd1);

    // 3: hysteresis band holds near; interrupted far run restarts
    applyStimulus(2'b01, 11, 0);
    applyStimulus(2'b01, 11, 0);
    applyStimulus(2'b01, 11, 0);
    checkOutput("t3_band", 32'(proximo), 32'd1);
    applyStimulus(2'b01, 12, 0);
    applyStimulus(2'b01, 12, 0);
    applyStimulus(2'b01, 11, 0);
    applyStimulus(2'b01, 12, 0);
    checkOutput("t3_interrupted", 32'(proximo), 32'd1);
    applyStimulus(2'b01, 12, 0);
    checkOutput("t3_confirming", 32'(proximo), 32'd1);
    applyStimulus(2'b01, 12, 0);
    checkOutput("t3_far", 32'(proximo), 32'd0);
    checkOutput("t3_evento_not_yet", 32'(evento), 32'd0);
    applyStimulus(2'b01, 12, 0);
    checkOutput("t3_evento", 32'(evento), 32'd1);
    checkOutput("t3_still_far", 32'(proximo), 32'd0);
    idleCycle();
    checkOutput("t3_evento_end", 32'(evento), 32'd0);

    // 4: nearest channel selection, tie to lowest index, joint release
    pulseReset();
    applyStimulus(2'b11, 8, 5);
    applyStimulus(2'b11, 8, 5);
    applyStimulus(2'b11, 8, 5);
    checkOutput("t4_both_near", 32'(proximo), 32'd3);
    idleCycle();
    checkOutput("t4_canal1", 32'(canal_mais_proximo), 32'd1);
    checkOutput("t4_algum", 32'(algum_proximo), 32'd1);
    checkOutput("t4_evento_both", 32'(evento), 32'd1);
    applyStimulus(2'b10, 0, 8);
    idleCycle();
    checkOutput("t4_tie_canal0", 32'(canal_mais_proximo), 32'd0);
    checkOutput("t4_tie_evento", 32'(evento), 32'd0);
    applyStimulus(2'b11, 12, 12);
    applyStimulus(2'b11, 12, 12);
    checkOutput("t4_confirming", 32'(proximo), 32'd3);
    applyStimulus(2'b11, 12, 12);
    checkOutput("t4_both_far", 32'(proximo), 32'd0);
    idleCycle();
    checkOutput("t4_far_evento", 32'(evento), 32'd1);
    checkOutput("t4_far_algum", 32'(algum_proximo), 32'd0);
    checkOutput("t4_far_canal", 32'(canal_mais_proximo), 32'd0);
    idleCycle();
    checkOutput("t4_single_pulse", 32'(evento), 32'd0);

    // 5: asynchronous reset mid-confirmation
    pulseReset();
    applyStimulus(2'b10, 0, 5);
    applyStimulus(2'b10, 0, 5);
    applyStimulus(2'b10, 0, 5);
    idleCycle();
    checkOutput("t5_ch1_near", 32'(algum_proximo), 32'd1);
    applyStimulus(2'b01, 9, 0);
    applyStimulus(2'b01, 9, 0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_async_proximo", 32'(proximo), 32'd0);
    checkOutput("t5_async_algum", 32'(algum_proximo), 32'd0);
    checkOutput("t5_async_canal", 32'(canal_mais_proximo), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(2'b01, 9, 0);
    applyStimulus(2'b01, 9, 0);
    checkOutput("t5_count_discarded", 32'(proximo), 32'd0);
    applyStimulus(2'b01, 9, 0);
    checkOutput("t5_reconfirmed", 32'(proximo), 32'd1);

    // 6: threshold extremes
    pulseReset();
    limiar = 12'd4095;
    applyStimulus(2'b10, 0, 100);
    applyStimulus(2'b10, 0, 100);
    applyStimulus(2'b10, 0, 100);
    checkOutput("t6_ch1_near", 32'(proximo), 32'd2);
    for (int k = 0; k < 5; k++) applyStimulus(2'b10, 0, 4095);
    checkOutput("t6_no_wrap", 32'(proximo), 32'd2);
    limiar = 12'd0;
    for (int k = 0; k < 4; k++) applyStimulus(2'b01, 0, 0);
    checkOutput("t6_limiar0", 32'(proximo), 32'd2);
    idleCycle();
    checkOutput("t6_canal", 32'(canal_mais_proximo), 32'd1);
    checkOutput("t6_algum", 32'(algum_proximo), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
